// File: rtl/ethzurich_pkg.sv
// ethzurich_pkg: opcodes, flag positions and pin constants for the accumulator ALU tile
package ethzurich_pkg;
  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_ADC  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_SHL  = 3'd7;
  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_C = 5;
  localparam int FLAG_V = 4;
  localparam logic [7:0] UIO_OE_MASK = 8'hF0;
endpackage

// File: rtl/ethzurich_alu.sv
// ethzurich_alu: combinational 8-op ALU producing result and Z/N/C/V flags
module ethzurich_alu
  import ethzurich_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] op,
  input  logic       c_in,
  output logic [7:0] r,
  output logic       z,
  output logic       n,
  output logic       c,
  output logic       v
);
  logic        is_add, is_sub, is_shl;
  logic [8:0]  add9, sub9;
  logic [15:0] shl16;
  assign is_add = (op == OP_ADD) || (op == OP_ADC);
  assign is_sub = op == OP_SUB;
  assign is_shl = op == OP_SHL;
  assign add9   = {1'b0, a} + {1'b0, b} + {8'd0, (op == OP_ADC) & c_in};
  assign sub9   = {1'b0, a} - {1'b0, b};
  // bit 8 of the widened shift is the last bit shifted out; zero for shift 0
  assign shl16  = {8'd0, a} << b[2:0];
  always_comb begin
    r = is_add ? add9[7:0] :
        is_sub ? sub9[7:0] :
        is_shl ? shl16[7:0] :
        op == OP_AND ? a & b :
        op == OP_OR  ? a | b :
        op == OP_XOR ? a ^ b : b;
    c = is_add ? add9[8] : is_sub ? sub9[8] : is_shl ? shl16[8] : 1'b0;
    v = is_add ? (a[7] == b[7]) && (r[7] != a[7]) :
        is_sub ? (a[7] != b[7]) && (r[7] != a[7]) : 1'b0;
    z = r == 8'd0;
    n = r[7];
  end
endmodule

// File: rtl/tt_um_abdulhaseebahb_ethzurich.sv
// tt_um_abdulhaseebahb_ethzurich: TinyTapeout accumulator ALU tile with registered flags
module tt_um_abdulhaseebahb_ethzurich
  import ethzurich_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [7:0] acc, r;
  logic       z_q, n_q, c_q, v_q, z, n, c, v;
  logic       unused_ok;
  assign unused_ok = &{1'b0, uio_in[7:4]};
  ethzurich_alu u_alu (
    .a(acc), .b(ui_in), .op(uio_in[2:0]), .c_in(c_q),
    .r(r), .z(z), .n(n), .c(c), .v(v)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= 8'h00;
      {z_q, n_q, c_q, v_q} <= 4'b1000;
    end else if (ena && uio_in[3]) begin
      acc <= r;
      {z_q, n_q, c_q, v_q} <= {z, n, c, v};
    end
  end
  always_comb begin
    uio_out = 8'h00;
    uio_out[FLAG_Z] = z_q;
    uio_out[FLAG_N] = n_q;
    uio_out[FLAG_C] = c_q;
    uio_out[FLAG_V] = v_q;
  end
  assign uo_out = acc;
  assign uio_oe = UIO_OE_MASK;
endmodule

// File: tb/tb_tt_um_abdulhaseebahb_ethzurich.sv
// tb_tt_um_abdulhaseebahb_ethzurich: directed self-checking bench for the accumulator ALU tile
module tb_tt_um_abdulhaseebahb_ethzurich;
  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  int         n_chk = 0, n_ok = 0;
  tt_um_abdulhaseebahb_ethzurich dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic cmd(input logic [2:0] op, input logic [7:0] b);
    uio_in = {4'hA, 1'b1, op};
    ui_in  = b;
    @(posedge clk);
    #1;
    uio_in[3] = 1'b0;
  endtask
  task automatic expect_state(input string tag, input logic [7:0] a, input logic [7:0] f);
    chk({tag, "_a"}, uo_out, a);
    chk({tag, "_f"}, uio_out, f);
  endtask
  initial begin
    rst_n = 1'b0; ena = 1'b1; uio_in = 8'h08; ui_in = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    expect_state("reset", 8'h00, 8'h80);
    chk("oe", uio_oe, 8'hF0);
    rst_n = 1'b1; uio_in = 8'h00;
    cmd(3'd0, 8'h7F); expect_state("ld7f", 8'h7F, 8'h00);
    cmd(3'd1, 8'h01); expect_state("add_ovf", 8'h80, 8'h50);
    cmd(3'd0, 8'hFF); expect_state("ldff", 8'hFF, 8'h40);
    cmd(3'd1, 8'h01); expect_state("add_wrap", 8'h00, 8'hA0);
    cmd(3'd3, 8'h00); expect_state("adc0", 8'h01, 8'h00);
    cmd(3'd0, 8'h10); cmd(3'd2, 8'h20); expect_state("sub_brw", 8'hF0, 8'h60);
    cmd(3'd2, 8'hF0); expect_state("sub_zero", 8'h00, 8'h80);
    cmd(3'd0, 8'h80); cmd(3'd2, 8'h01); expect_state("sub_ovf", 8'h7F, 8'h10);
    cmd(3'd0, 8'h81); cmd(3'd7, 8'h01); expect_state("shl1", 8'h02, 8'h20);
    cmd(3'd7, 8'hF8); expect_state("shl0", 8'h02, 8'h00);
    cmd(3'd0, 8'h81); cmd(3'd7, 8'h07); expect_state("shl7", 8'h80, 8'h40);
    cmd(3'd0, 8'hF0); cmd(3'd4, 8'h3C); expect_state("and", 8'h30, 8'h00);
    cmd(3'd5, 8'h0F); expect_state("or", 8'h3F, 8'h00);
    cmd(3'd6, 8'h3F); expect_state("xor", 8'h00, 8'h80);
    cmd(3'd0, 8'hFF); cmd(3'd1, 8'h01); cmd(3'd3, 8'hFF); expect_state("adc_cin", 8'h00, 8'hA0);
    ena = 1'b0; cmd(3'd0, 8'hAA); expect_state("ena0", 8'h00, 8'hA0);
    ena = 1'b1; uio_in = 8'h00; ui_in = 8'hAA; @(posedge clk); #1;
    expect_state("valid0", 8'h00, 8'hA0);
    cmd(3'd0, 8'h00);
    uio_in = 8'h09; ui_in = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    uio_in = 8'h00;
    expect_state("b2b", 8'h02, 8'h00);
    cmd(3'd0, 8'hC3);
    rst_n = 1'b0; ena = 1'b0; @(posedge clk); #1;
    expect_state("rst_ena0", 8'h00, 8'h80);
    chk("oe_rst", uio_oe, 8'hF0);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
